// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, bubble word and PC step.
// Pure definitions; no logic, no latency, no flow control.
package instruction_fetch_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned WORD_W   = 32;

    // Bubble word: all-ones opcode, zero payload (matches the memory's default output)
    localparam logic [WORD_W-1:0] IF_NOP_WORD = {{OPCODE_W{1'b1}}, {(WORD_W-OPCODE_W){1'b0}}};

    localparam logic [WORD_W-1:0] PC_INC    = 32'd4;
    localparam logic [WORD_W-1:0] WORD_MASK = 32'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } if_state_t;

    // Drop the byte-offset bits so fetches always land on a word boundary
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_MASK;
    endfunction

    function automatic logic misaligned(input logic [WORD_W-1:0] addr);
        return (addr & WORD_MASK) != '0;
    endfunction

    // Redirect beats stall; stall beats normal fetch
    function automatic if_state_t next_state(input logic redirect, input logic stall);
        if (redirect)
            return ST_FLUSH;
        else if (stall)
            return ST_HOLD;
        else
            return ST_RUN;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter: reset load, redirect load (word aligned), hold, or +4 with mod-2^32 wrap.
// Latency: new PC visible one cycle after the controlling edge; pc_plus4 is combinational.
// Backpressure: advance=0 and load=0 holds the PC indefinitely.
module instruction_fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] load_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + PC_INC;

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (load)
            pc <= word_align(load_addr);
        else if (advance)
            pc <= pc_plus4;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives PC to instruction memory and registers the returned word into IF/ID.
// Latency: memory word appears on if_id_* one cycle after the fetch edge.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall and inserts one bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_com,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch;

    assign fetch     = !redirect && !stall;
    assign imem_addr = pc;

    instruction_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .advance   (fetch),
        .load      (redirect),
        .load_addr (redirect_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            if_id_instr  <= NOP_WORD;
            if_id_pc4    <= '0;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            // All legal states share the same transition rule; an illegal encoding recovers to RUN
            case (state)
                ST_RUN, ST_HOLD, ST_FLUSH: state <= next_state(redirect, stall);
                default:                   state <= ST_RUN;
            endcase

            if (redirect) begin
                // Bubble keeps the old pc4 so decode never sees a stale-but-valid pair
                if_id_instr <= NOP_WORD;
                if_id_valid <= 1'b0;
                if (misaligned(redirect_target))
                    misalign_err <= 1'b1;
            end else if (fetch) begin
                // A NOP_WORD coming from memory is still a real instruction here
                if_id_instr <= imem_com;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised + directed bench for instruction_fetch with a queue-based scoreboard.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hFC000000;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_com;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: what the fetch stage should look like after the next edge
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_cnt;

    instruction_fetch #(
        .RESET_PC (32'h00000000),
        .NOP_WORD (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_com        (imem_com),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    assign imem_com = mem[imem_addr[9:2]];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every edge the DUT presents a new IF/ID state; compare against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr",    imem_addr,           e.pc);
            chk("if_id_instr",  if_id_instr,         e.instr);
            chk("if_id_pc4",    if_id_pc4,           e.pc4);
            chk("if_id_valid",  {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            chk("fetch_count",  fetch_count,         e.cnt);
        end
    end

    // Apply one cycle of inputs, advance the reference model, queue the expected result
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
        exp_t e;
        reset           = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (rd) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_instr = NOP;
            m_valid = 1'b0;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        end else if (!s) begin
            m_instr = mem[m_pc[9:2]];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        m_pc = '0; m_instr = NOP; m_pc4 = '0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? NOP : $urandom;
        mem[0] = 32'h20100007;
        mem[1] = 32'hAC100001;
        mem[2] = 32'h8C130001;
        mem[255] = 32'h0BADF00D;

        // Reset, with stall/redirect also high to show reset wins
        step(1, 0, 0, 32'h0);
        step(1, 1, 1, 32'h0000_0040);
        // Straight-line fetch of 0/4 then stall two cycles at PC=8, resume
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // PC=C: redirect to 0x18, bubble then word at 0x18
        step(0, 0, 1, 32'h0000_0018);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // Redirect with stall: redirect wins; then stall during FLUSH follow-up
        step(0, 1, 1, 32'h0000_0040);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // Misaligned target 0x22 -> PC 0x20, sticky error
        step(0, 0, 1, 32'h0000_0022);
        step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // Back-to-back redirects
        step(0, 0, 1, 32'h0000_0008);
        step(0, 0, 1, 32'h0000_0010);
        step(0, 1, 0, 32'h0);
        // Reset during HOLD at PC=0x10 discards everything, including misalign_err
        step(1, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        // PC wrap: FFFFFFFC -> 00000000
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);

        // Random mix of stall, redirect (aligned and misaligned), and occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) == 0);
            rd = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(r, s, rd, t);
        end

        step(0, 0, 0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: got time %0t expected completion before it", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, meaning: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'hFC000000, meaning: bubble word (opcode 111111), equal to the instruction memory default output.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  fetch address driven to instruction memory.
REQ-006 imem_com  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 stall  input  1  hazard hold request from decode/hazard logic.
REQ-008 redirect  input  1  taken branch or jump resolved in decode.
REQ-009 redirect_target  input  32  byte address to fetch after redirect.
REQ-010 if_id_instr  output  32  registered instruction for the decode stage.
REQ-011 if_id_pc4  output  32  registered PC+4 of if_id_instr.
REQ-012 if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.
REQ-013 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-014 fetch_count  output  32  number of instructions fetched into IF/ID.

Function
REQ-015 imem_addr shall equal the PC register combinationally; there are no other paths to it.
REQ-016 The FSM shall have three states: RUN, HOLD, and FLUSH; it enters RUN from reset.
REQ-017 RUN with stall=0 and redirect=0: PC <= PC+4, if_id_instr <= imem_com, if_id_pc4 <= PC+4, if_id_valid <= 1, fetch_count <= fetch_count+1; stay in RUN.
REQ-018 stall=1 and redirect=0: PC, if_id_instr, if_id_pc4, if_id_valid, and fetch_count shall all hold; next state is HOLD.
REQ-019 HOLD with stall=0: the next cycle resumes RUN behaviour at the held PC; no instruction shall be skipped or duplicated.
REQ-020 redirect=1 (any state, regardless of stall): PC <= {redirect_target[31:2],2'b00}, if_id_instr <= NOP_WORD, if_id_valid <= 0, and if_id_pc4 holds; next state is FLUSH.
REQ-021 Redirect shall take priority over stall.
REQ-022 FLUSH shall last exactly one cycle, then behave as RUN or HOLD according to stall; the first post-redirect fetch shall reach IF/ID one cycle after the redirect edge.
REQ-023 redirect=1 with redirect_target[1:0]!=0 shall set misalign_err, which stays set until reset.
REQ-024 PC+4 shall wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); fetch_count shall also wrap modulo 2^32.
REQ-025 A NOP_WORD returned by memory during RUN shall be latched with if_id_valid=1; only flush bubbles carry valid=0.

Reset
REQ-026 reset=1 at a clock edge: PC <= RESET_PC, if_id_instr <= NOP_WORD, if_id_pc4 <= 0, if_id_valid <= 0, misalign_err <= 0, fetch_count <= 0, and state <= RUN.
REQ-027 Reset shall override stall and redirect in the same cycle; asserting reset mid-HOLD or mid-FLUSH shall discard all pending state.
REQ-028 The first fetch after reset deassertion shall read RESET_PC.

Structure
REQ-029 Shared package: FSM state encoding, NOP_WORD value, opcode width, and PC increment constant 4.
REQ-030 One sub-module: pc_reg (PC register with reset load, hold, increment, and redirect mux); the IF/ID register and FSM shall stay in instruction_fetch.

Verification
REQ-031 Reset, memory at 0/4/8 = 32'h20100007/32'hAC100001/32'h8C130001, no stall -> if_id_instr shows those three words on cycles 1-3, if_id_pc4 = 4/8/C, fetch_count = 3.
REQ-032 stall high for 2 cycles while PC=8 -> IF/ID holds 32'hAC100001 with pc4=8 for 2 cycles, then 32'h8C130001 follows; no skip.
REQ-033 redirect=1 with target 32'h00000018 while PC=C -> next IF/ID = NOP_WORD with valid=0, then the word at 18 with pc4=1C.
REQ-034 redirect and stall both high -> redirect wins; PC=target and a bubble is inserted.
REQ-035 redirect target 32'h00000022 -> PC=32'h00000020 and misalign_err=1, held until reset.
REQ-036 Reset asserted during HOLD at PC=10 -> next cycle PC=0, valid=0, fetch_count=0.
